// File: rtl/alu_issue_if.sv
// Issue-stage bus: upstream instruction handshake plus the decoded op toward execute.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry the stall in each direction.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctr;
  logic [4:0]  rd;
  logic        rd_wen;
  logic        is_branch;
  logic [2:0]  br_f3;
  logic        illegal;

  // Driver side: supplies instructions and consumes issued ops.
  modport master (
    output in_valid, inst, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_ctr, rd, rd_wen, is_branch, br_f3, illegal
  );

  // Stage side.
  modport slave (
    input  in_valid, inst, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_ctr, rd, rd_wen, is_branch, br_f3, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I decode-and-issue: turns one instruction into ALU control code and operands.
// Latency: 1 cycle from accept to out_valid; throughput 1 op/cycle.
// Backpressure: single output slot; in_ready = !out_valid || out_ready.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [3:0] CTR_ADD   = 4'b0000;
  localparam logic [3:0] CTR_SUB   = 4'b1000;
  localparam logic [3:0] CTR_SLL   = 4'b0001;
  localparam logic [3:0] CTR_SLT   = 4'b0010;
  localparam logic [3:0] CTR_SLTU  = 4'b1010;
  localparam logic [3:0] CTR_PASSB = 4'b0011;
  localparam logic [3:0] CTR_SRL   = 4'b0101;
  localparam logic [3:0] CTR_SRA   = 4'b1101;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctr;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        is_branch;
    logic [2:0]  br_f3;
    logic        illegal;
  } issue_t;

  // Base funct3 -> ALU code; only SLTU differs from a plain zero-extension.
  function automatic logic [3:0] f3_ctr(input logic [2:0] f3);
    return (f3 == 3'b011) ? CTR_SLTU : {1'b0, f3};
  endfunction

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] u_imm;
  logic [31:0] shamt;

  assign opc   = bus.inst[6:0];
  assign f3    = bus.inst[14:12];
  assign f7    = bus.inst[31:25];
  assign i_imm = {{20{bus.inst[31]}}, bus.inst[31:20]};
  assign s_imm = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
  assign u_imm = {bus.inst[31:12], 12'b0};
  assign shamt = {27'b0, bus.inst[24:20]};

  issue_t dec;
  issue_t slot;
  logic   legal;
  logic   wen_ok;
  logic   accept;
  logic   out_valid_q;

  // Decode the presented instruction; illegal cases collapse to a zeroed ADD.
  always_comb begin
    dec        = '0;
    dec.rd     = bus.inst[11:7];
    dec.ctr    = CTR_ADD;
    legal      = 1'b1;
    wen_ok     = 1'b1;
    case (opc)
      OPC_OP: begin
        dec.a = bus.rs1_data;
        dec.b = bus.rs2_data;
        if (f7 == F7_ZERO)                    dec.ctr = f3_ctr(f3);
        else if (f7 == F7_ALT && f3 == 3'b000) dec.ctr = CTR_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) dec.ctr = CTR_SRA;
        else                                   legal   = 1'b0;
      end
      OPC_OP_IMM: begin
        dec.a = bus.rs1_data;
        if (f3 == 3'b001) begin
          dec.b   = shamt;
          dec.ctr = CTR_SLL;
          if (f7 != F7_ZERO) legal = 1'b0;
        end else if (f3 == 3'b101) begin
          dec.b = shamt;
          if (f7 == F7_ZERO)     dec.ctr = CTR_SRL;
          else if (f7 == F7_ALT) dec.ctr = CTR_SRA;
          else                   legal   = 1'b0;
        end else begin
          dec.b   = i_imm;
          dec.ctr = f3_ctr(f3);
        end
      end
      OPC_LUI: begin
        dec.b   = u_imm;
        dec.ctr = CTR_PASSB;
      end
      OPC_AUIPC: begin
        dec.a = bus.pc;
        dec.b = u_imm;
      end
      OPC_JAL: begin
        dec.a = bus.pc;
        dec.b = 32'd4;
      end
      OPC_JALR: begin
        dec.a = bus.pc;
        dec.b = 32'd4;
        if (f3 != 3'b000) legal = 1'b0;
      end
      OPC_BRANCH: begin
        dec.a         = bus.rs1_data;
        dec.b         = bus.rs2_data;
        dec.is_branch = 1'b1;
        dec.br_f3     = f3;
        wen_ok        = 1'b0;
        case (f3)
          3'b000, 3'b001: dec.ctr = CTR_SUB;
          3'b100, 3'b101: dec.ctr = CTR_SLT;
          3'b110, 3'b111: dec.ctr = CTR_SLTU;
          default:        legal   = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec.a = bus.rs1_data;
        dec.b = i_imm;
      end
      OPC_STORE: begin
        dec.a  = bus.rs1_data;
        dec.b  = s_imm;
        wen_ok = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.a         = '0;
      dec.b         = '0;
      dec.ctr       = CTR_ADD;
      dec.is_branch = 1'b0;
      dec.br_f3     = '0;
    end
    dec.illegal = !legal;
    dec.rd_wen  = legal && wen_ok && (bus.inst[11:7] != 5'd0);
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Output slot: load on accept, drain on consume, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      slot        <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      slot        <= dec;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.alu_a     = slot.a;
  assign bus.alu_b     = slot.b;
  assign bus.alu_ctr   = slot.ctr;
  assign bus.rd        = slot.rd;
  assign bus.rd_wen    = slot.rd_wen;
  assign bus.is_branch = slot.is_branch;
  assign bus.br_f3     = slot.br_f3;
  assign bus.illegal   = slot.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, back-to-back issue, stall and reset.
// Latency: checks outputs one edge after accept, sampled 1ns after posedge.
// Backpressure: exercises out_ready stalls and same-cycle consume/accept.
module tb_alu_issue;
  logic clk;
  logic rst;
  alu_issue_if bus ();

  alu_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_fail;

  // {out_valid, a, b, ctr, rd, rd_wen, is_branch, br_f3, illegal}
  logic [79:0] snap;
  assign snap = {bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_ctr, bus.rd,
                 bus.rd_wen, bus.is_branch, bus.br_f3, bus.illegal};

  function automatic logic [79:0] pack(input logic v, input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] ctr, input logic [4:0] rd, input logic wen,
                                       input logic br, input logic [2:0] f3, input logic ill);
    return {v, a, b, ctr, rd, wen, br, f3, ill};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid = 1'b1;
    bus.inst     = i;
    bus.pc       = p;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
  endtask

  task automatic test_reset();
    logic [79:0] exp;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp = '0;
    n_checks++;
    if (snap !== exp) begin n_fail++; $display("FAIL reset_state: got %h want %h", snap, exp); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_addi();
    logic [79:0] exp;
    bus.out_ready = 1'b1;
    drive(32'h00500093, 32'h0, 32'h0, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    exp = pack(1'b1, 32'd0, 32'd5, 4'b0000, 5'd1, 1'b1, 1'b0, 3'd0, 1'b0);
    n_checks++;
    if (snap !== exp) begin n_fail++; $display("FAIL addi: got %h want %h", snap, exp); end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_decode();
    logic [79:0] exp;
    bus.out_ready = 1'b1;
    // sub x3,x1,x2
    drive(32'h402081B3, 32'h0, 32'd9, 32'd4);
    tick();
    exp = pack(1'b1, 32'd9, 32'd4, 4'b1000, 5'd3, 1'b1, 1'b0, 3'd0, 1'b0);
    n_checks++;
    if (snap !== exp) begin n_fail++; $display("FAIL sub: got %h want %h", snap, exp); end
    // jal x1,0 at pc 0x100: link = pc + 4
    drive(32'h000000EF, 32'h100, 32'h0, 32'h0);
    tick();
    exp = pack(1'b1, 32'h100, 32'd4, 4'b0000, 5'd1, 1'b1, 1'b0, 3'd0, 1'b0);
    n_checks++;
    if (snap !== exp) begin n_fail++; $display("FAIL jal: got %h want %h", snap, exp); end
    // addi x0,x0,5: rd == 0 suppresses writeback
    drive(32'h00500013, 32'h0, 32'h0, 32'h0);
    tick();
    exp = pack(1'b1, 32'd0, 32'd5, 4'b0000, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    n_checks++;
    if (snap !== exp) begin n_fail++; $display("FAIL addi_x0: got %h want %h", snap, exp); end
    // OP with funct7 0000001 is not RV32I
    drive(32'h022080B3, 32'h0, 32'd9, 32'd4);
    tick();
    exp = pack(1'b1, 32'd0, 32'd0, 4'b0000, 5'd1, 1'b0, 1'b0, 3'd0, 1'b1);
    n_checks++;
    if (snap !== exp) begin n_fail++; $display("FAIL op_bad_f7: got %h want %h", snap, exp); end
    // all-ones word: unknown opcode
    drive(32'hFFFFFFFF, 32'h40, 32'd1, 32'd2);
    tick();
    exp = pack(1'b1, 32'd0, 32'd0, 4'b0000, 5'd31, 1'b0, 1'b0, 3'd0, 1'b1);
    n_checks++;
    if (snap !== exp) begin n_fail++; $display("FAIL illegal_ones: got %h want %h", snap, exp); end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [79:0] exp;
    bus.out_ready = 1'b1;
    drive(32'h40335293, 32'h0, 32'h80000000, 32'h0);
    tick();
    exp = pack(1'b1, 32'h80000000, 32'd3, 4'b1101, 5'd5, 1'b1, 1'b0, 3'd0, 1'b0);
    n_checks++;
    if (snap !== exp) begin n_fail++; $display("FAIL b2b_srai: got %h want %h", snap, exp); end
    drive(32'h123453B7, 32'h0, 32'h0, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    exp = pack(1'b1, 32'd0, 32'h12345000, 4'b0011, 5'd7, 1'b1, 1'b0, 3'd0, 1'b0);
    n_checks++;
    if (snap !== exp) begin n_fail++; $display("FAIL b2b_lui: got %h want %h", snap, exp); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [79:0] exp_a;
    logic [79:0] exp_b;
    // addi x2,x0,-1 with rs1 = 7: sign-extended immediate
    bus.out_ready = 1'b0;
    drive(32'hFFF00113, 32'h0, 32'd7, 32'h0);
    tick();
    exp_a = pack(1'b1, 32'd7, 32'hFFFFFFFF, 4'b0000, 5'd2, 1'b1, 1'b0, 3'd0, 1'b0);
    // sw x2,8(x1): STORE never writes back; rd field carries imm[4:0]
    drive(32'h0020A423, 32'h0, 32'h1000, 32'h55);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b want 0", k, bus.in_ready); end
      n_checks++;
      if (snap !== exp_a) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", k, snap, exp_a); end
      tick();
    end
    n_checks++;
    if (snap !== exp_a) begin n_fail++; $display("FAIL stall_hold_end: got %h want %h", snap, exp_a); end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    exp_b = pack(1'b1, 32'h1000, 32'd8, 4'b0000, 5'd8, 1'b0, 1'b0, 3'd0, 1'b0);
    n_checks++;
    if (snap !== exp_b) begin n_fail++; $display("FAIL release_store: got %h want %h", snap, exp_b); end
    tick();
  endtask

  task automatic test_branch_reset();
    logic [79:0] exp;
    bus.out_ready = 1'b0;
    drive(32'h0020E463, 32'h200, 32'd3, 32'd5);
    tick();
    bus.in_valid = 1'b0;
    exp = pack(1'b1, 32'd3, 32'd5, 4'b1010, 5'd8, 1'b0, 1'b1, 3'b110, 1'b0);
    n_checks++;
    if (snap !== exp) begin n_fail++; $display("FAIL bltu: got %h want %h", snap, exp); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp = '0;
    n_checks++;
    if (snap !== exp) begin n_fail++; $display("FAIL reset_mid_stall: got %h want %h", snap, exp); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.inst      = 32'h0;
    bus.pc        = 32'h0;
    bus.rs1_data  = 32'h0;
    bus.rs2_data  = 32'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_addi();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_branch_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
